// File: rtl/toast_id_issue.sv
// Decode-to-execute issue register: valid/ready handshake with a 2-entry skid buffer
// (output slot O, skid slot S), load-use bubble insertion and a saturating bubble counter.
module toast_id_issue #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned REGFILE_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH         = 24,
    parameter bit          LOAD_USE_CHECK     = 1'b1,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [XLEN-1:0]               in_pc_i,
    input  logic [XLEN-1:0]               in_imm_i,
    input  logic [CTRL_WIDTH-1:0]         in_ctrl_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] in_rs1_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] in_rs2_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] in_rd_addr_i,
    input  logic                          in_use_rs1_i,
    input  logic                          in_use_rs2_i,
    input  logic                          in_rd_wr_en_i,
    input  logic                          in_mem_rd_en_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [XLEN-1:0]               out_pc_o,
    output logic [XLEN-1:0]               out_imm_o,
    output logic [CTRL_WIDTH-1:0]         out_ctrl_o,
    output logic [REGFILE_ADDR_WIDTH-1:0] out_rs1_addr_o,
    output logic [REGFILE_ADDR_WIDTH-1:0] out_rs2_addr_o,
    output logic [REGFILE_ADDR_WIDTH-1:0] out_rd_addr_o,
    output logic                          out_use_rs1_o,
    output logic                          out_use_rs2_o,
    output logic                          out_rd_wr_en_o,
    output logic                          out_mem_rd_en_o,
    output logic [CNT_WIDTH-1:0]          bubble_count_o
);

    localparam int unsigned RA = REGFILE_ADDR_WIDTH;
    localparam int unsigned PW = 2 * XLEN + CTRL_WIDTH + 3 * RA + 4;

    logic [PW-1:0]        in_pl;
    logic [PW-1:0]        o_q, o_d, s_q, s_d;
    logic                 o_valid_q, o_valid_d;
    logic                 s_valid_q, s_valid_d;
    logic                 haz_valid_q, haz_valid_d;
    logic [RA-1:0]        haz_rd_q, haz_rd_d;
    logic [CNT_WIDTH-1:0] bubble_q, bubble_d;

    logic in_fire, out_fire, o_free, hazard;

    assign in_pl = {in_pc_i, in_imm_i, in_ctrl_i, in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i,
                    in_use_rs1_i, in_use_rs2_i, in_rd_wr_en_i, in_mem_rd_en_i};

    assign {out_pc_o, out_imm_o, out_ctrl_o, out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o,
            out_use_rs1_o, out_use_rs2_o, out_rd_wr_en_o, out_mem_rd_en_o} = o_q;

    // Consumer in O reads the register a just-issued load is still fetching.
    assign hazard = haz_valid_q & o_valid_q &
                    ((out_use_rs1_o & (out_rs1_addr_o == haz_rd_q)) |
                     (out_use_rs2_o & (out_rs2_addr_o == haz_rd_q)));

    assign in_ready_o     = ~s_valid_q;
    assign out_valid_o    = o_valid_q & ~hazard;
    assign in_fire        = in_valid_i & in_ready_o;
    assign out_fire       = out_valid_o & out_ready_i;
    assign o_free         = ~o_valid_q | out_fire;
    assign bubble_count_o = bubble_q;

    always_comb begin
        o_d         = o_q;
        s_d         = s_q;
        o_valid_d   = o_valid_q;
        s_valid_d   = s_valid_q;
        haz_valid_d = haz_valid_q;
        haz_rd_d    = haz_rd_q;
        bubble_d    = bubble_q;

        if (o_free) begin
            if (s_valid_q) begin
                o_d       = s_q;
                o_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else if (in_fire) begin
                o_d       = in_pl;
                o_valid_d = 1'b1;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            s_d       = in_pl;
            s_valid_d = 1'b1;
        end

        if (LOAD_USE_CHECK && out_fire && out_mem_rd_en_o && out_rd_wr_en_o &&
            (out_rd_addr_o != '0)) begin
            haz_valid_d = 1'b1;
            haz_rd_d    = out_rd_addr_o;
        end else if (out_ready_i) begin
            haz_valid_d = 1'b0;
        end

        if (hazard && out_ready_i && (bubble_q != {CNT_WIDTH{1'b1}})) begin
            bubble_d = bubble_q + CNT_WIDTH'(1);
        end

        // Payloads may still load; only the valids are dropped.
        if (flush_i) begin
            o_valid_d   = 1'b0;
            s_valid_d   = 1'b0;
            haz_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            o_q         <= '0;
            s_q         <= '0;
            o_valid_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            haz_valid_q <= 1'b0;
            haz_rd_q    <= '0;
            bubble_q    <= '0;
        end else begin
            o_q         <= o_d;
            s_q         <= s_d;
            o_valid_q   <= o_valid_d;
            s_valid_q   <= s_valid_d;
            haz_valid_q <= haz_valid_d;
            haz_rd_q    <= haz_rd_d;
            bubble_q    <= bubble_d;
        end
    end

endmodule

// File: doc/toast_id_issue.md
# toast_id_issue

Parametrised decode-to-execute issue register, the successor of the fixed ID pipeline register. It replaces the stall-and-zero scheme with a valid/ready handshake backed by a 2-entry skid buffer (output slot O, skid slot S). It adds internal load-use hazard detection with bubble insertion and a saturating bubble counter. It sits between the decoder/regfile read and the EX stage; the decoded control bundle is opaque except for the fields named below.

## Interface
- XLEN, 32, PC/immediate width
- REGFILE_ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 24, opaque decoded control bundle width
- LOAD_USE_CHECK, 1, 1 = hazard detection enabled; 0 = hazard forced low
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk_i  in  1  clock, rising edge
- resetn_i  in  1  reset; one clock; asynchronous, active-low
- flush_i  in  1  synchronous flush (branch/jump redirect)
- in_valid_i  in  1  upstream instruction valid
- in_ready_o  out  1  block can accept (registered, equals !S_valid)
- in_pc_i  in  XLEN  instruction PC
- in_imm_i  in  XLEN  decoded immediate
- in_ctrl_i  in  CTRL_WIDTH  opaque control bundle
- in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i  in  REGFILE_ADDR_WIDTH  register addresses
- in_use_rs1_i, in_use_rs2_i  in  1  instruction reads rs1/rs2
- in_rd_wr_en_i  in  1  instruction writes rd
- in_mem_rd_en_i  in  1  instruction is a load
- out_valid_o  out  1  O_valid & !hazard
- out_ready_i  in  1  EX accepts
- out_pc_o, out_imm_o, out_ctrl_o, out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o, out_use_rs1_o, out_use_rs2_o, out_rd_wr_en_o, out_mem_rd_en_o  out  same widths as inputs  contents of slot O
- bubble_count_o  out  CNT_WIDTH  bubbles inserted since reset

## Operation
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- O free = !O_valid | out_fire.
- O free and S_valid: S moves to O; S empties.
- O free, S empty, in_fire: input loads O.
- in_fire while O not free: input loads S. Acceptance with S_valid is impossible because in_ready_o = 0.
- Entries never lost or duplicated; order preserved.
- Hazard (LOAD_USE_CHECK=1):
  - On out_fire of an entry with mem_rd_en & rd_wr_en & rd != 0, set haz_valid and latch haz_rd. Otherwise clear haz_valid on any cycle with out_ready_i = 1.
  - hazard = haz_valid & O_valid & ((use_rs1 & rs1 == haz_rd) | (use_rs2 & rs2 == haz_rd)).
  - While hazard, out_valid_o = 0 and O holds.
  - The bubble is delivered on the first hazard cycle with out_ready_i = 1, then haz_valid clears.
  - A non-dependent instruction in O issues with no bubble.
- bubble_count_o increments on each cycle with hazard & out_ready_i, saturating at all-ones. It is cleared only by reset; flush does not clear it.
- flush_i clears O_valid, S_valid and haz_valid at the next edge. Any in_fire in the same cycle is discarded. Flush has priority over all loads.
- Payload registers are not cleared by flush; only valids are.

## Timing
- Reset (async assert, sync deassert outside block): O_valid = S_valid = haz_valid = 0, in_ready_o = 1, out_valid_o = 0, all out_* payloads 0, bubble_count_o = 0.
- Latency: accepted at edge t, visible on out_* after edge t (one cycle).
- Throughput: 1 instruction/cycle with out_ready_i held high.
- in_ready_o is registered with no combinational path from out_ready_i. out_valid_o depends combinationally only on internal state.
- Backpressure: the first stalled cycle absorbs one in-flight instruction into S. in_ready_o falls the following cycle and returns 1 the cycle after S drains.
- Load-use costs exactly one bubble cycle, given out_ready_i high.
- Reset mid-transfer: all valids drop immediately; no partial entry survives.

## Test plan
- Streaming: 8 back-to-back instructions at PCs 0x00..0x1C, out_ready_i = 1 -> outputs appear one cycle after acceptance in order; in_ready_o stays 1; bubble_count_o = 0.
- Backpressure: out_ready_i low for 3 cycles during a stream -> exactly one entry enters S; in_ready_o = 0 from the second stall cycle; after release, PCs emerge in order with no loss or duplication.
- Load-use: lw x5 followed by add x6,x5,x7 (use_rs1 = 1) -> out_valid_o = 0 for one cycle between them; bubble_count_o = 1. Repeat with rd = x0 or consumer use_rs1 = 0 -> no bubble.
- Hazard plus stall: out_ready_i = 0 in the cycle after the load issues, then 1 -> bubble delivered on the first ready cycle; the consumer issues the next cycle; count increments once.
- Flush: flush_i asserted with O and S full and in_valid_i = 1 -> next cycle out_valid_o = 0 and in_ready_o = 1; the flushed PCs never appear; bubble_count_o unchanged.
- Reset mid-stream: resetn_i pulsed low asynchronously between edges -> out_valid_o = 0 immediately; all outputs at reset values; LOAD_USE_CHECK = 0 build shows no bubble on the load-use pair.
